// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one SRAM port across NUM_REQ requesters,
// one outstanding transaction at a time with a per-transaction timeout.
module sram_port_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int WIDTH    = 32,
  parameter int ADDR_BIT = 15,
  parameter int TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [NUM_REQ-1:0]           m_req,
  input  logic [NUM_REQ-1:0]           m_r0w1,
  input  logic [NUM_REQ*ADDR_BIT-1:0]  m_addr,
  input  logic [NUM_REQ*WIDTH-1:0]     m_wdata,
  output logic [NUM_REQ-1:0]           m_ack,
  output logic [NUM_REQ-1:0]           m_err,
  output logic [WIDTH-1:0]             m_rdata,
  output logic                         s_req,
  output logic                         s_r0w1,
  output logic [ADDR_BIT-1:0]          s_addr,
  output logic [WIDTH-1:0]             s_wdata,
  input  logic                         s_ack,
  input  logic [WIDTH-1:0]             s_rdata,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic [15:0]                  xfer_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t        state;
  logic [IW-1:0] ptr, g, pick;
  logic [TW-1:0] timer;
  // descending scan so the last hit is the nearest requester at or after ptr
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (m_req[IW'((int'(ptr) + k) % NUM_REQ)]) pick = IW'((int'(ptr) + k) % NUM_REQ);
    end
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      ptr      <= '0;
      g        <= '0;
      timer    <= '0;
      m_ack    <= '0;
      m_err    <= '0;
      m_rdata  <= '0;
      s_req    <= 1'b0;
      s_r0w1   <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|m_req) begin
          g       <= pick;
          s_r0w1  <= m_r0w1[pick];
          s_addr  <= m_addr[pick*ADDR_BIT +: ADDR_BIT];
          s_wdata <= m_wdata[pick*WIDTH +: WIDTH];
          s_req   <= 1'b1;
          grant   <= NUM_REQ'(1) << pick;
          timer   <= '0;
          busy    <= 1'b1;
          state   <= WAIT;
        end
        WAIT: if (s_ack || timer == TW'(TIMEOUT - 1)) begin
          s_req    <= 1'b0;
          m_ack    <= grant;
          m_err    <= s_ack ? '0 : grant;
          m_rdata  <= s_ack ? s_rdata : '0;
          ptr      <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
          xfer_cnt <= xfer_cnt + 16'd1;
          state    <= DONE;
        end else begin
          timer <= timer + 1'b1;
        end
        default: begin
          m_ack <= '0;
          m_err <= '0;
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
